// File: rtl/uart_rx_core.sv
// UART receive core.
// Deserialises an asynchronous serial line into WIDTH-bit words, LSB first,
// with no parity. An external baud generator supplies SAMPLING_TICKS baud_tick
// pulses per bit period. Every bit is sampled at its centre. The received word
// is held on rx_data_out, and the level flags rx_ready / rx_error describe the
// most recent frame.
// rst_n is a synchronous, active-HIGH reset. It keeps its historical name.
module uart_rx_core #(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16,
    parameter int STOP_BITS      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             baud_tick,
    output logic [WIDTH-1:0] rx_data_out,
    output logic             rx_ready,
    output logic             rx_error
);

    localparam int TICK_W = $clog2(SAMPLING_TICKS) + 1;
    localparam int BIT_W  = $clog2(WIDTH + 1);

    // Terminal counts: the tick that reaches the bit centre, and the tick
    // that completes one full bit period.
    localparam logic [TICK_W-1:0] TICK_MID_LAST = TICK_W'(SAMPLING_TICKS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_BIT_LAST = TICK_W'(SAMPLING_TICKS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST     = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST     = BIT_W'(STOP_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        r_sync;
    logic              r_rx_prev;
    logic [1:0]        r_state;
    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]  r_shift;
    logic              r_stop_err;

    logic w_rx_s;
    logic w_start_edge;
    logic w_tick_mid;
    logic w_tick_bit;
    logic w_stop_err;

    assign w_rx_s       = r_sync[1];
    assign w_start_edge = r_rx_prev & ~w_rx_s;
    assign w_tick_mid   = baud_tick && (r_tick == TICK_MID_LAST);
    assign w_tick_bit   = baud_tick && (r_tick == TICK_BIT_LAST);
    // The error accumulated over the earlier stop bits, plus the bit being sampled now.
    assign w_stop_err   = r_stop_err | ~w_rx_s;

    // Two-flop synchroniser and previous-sample register for edge detection.
    // These registers reset to the idle-high line level, so leaving reset
    // cannot look like a start bit.
    always_ff @(posedge clk) begin
        // NOTE: every register is written with non-blocking assignment so all
        // flops update together on the edge, whatever the statement order.
        if (rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    // Receive FSM: start qualification, data shift, stop check, result update.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_stop_err  <= 1'b0;
            rx_data_out <= '0;
            rx_ready    <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // baud_tick is ignored in this state. A line held low never
                    // retriggers, because only a 1 -> 0 transition starts a frame.
                    if (w_start_edge) begin
                        rx_ready   <= 1'b0;
                        rx_error   <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_tick     <= '0;
                        r_bit      <= '0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_tick_mid) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        // A high level at the start-bit centre was a glitch.
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else if (baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_tick_bit) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_s, r_shift[WIDTH-1:1]};
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else if (baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_tick_bit) begin
                        r_tick     <= '0;
                        r_stop_err <= w_stop_err;
                        if (r_bit == STOP_LAST) begin
                            // Results are published mid-stop-bit, so the next
                            // falling edge is caught even when frames arrive
                            // back to back.
                            r_bit       <= '0;
                            rx_data_out <= r_shift;
                            rx_ready    <= ~w_stop_err;
                            rx_error    <= w_stop_err;
                            r_state     <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else if (baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core (WIDTH=8, 16 ticks per bit, 1 stop bit).
// baud_tick fires once every 11 clk, so one bit period lasts 176 clk.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_uart_rx_core;

    localparam int TICK_DIV = 11;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       baud_tick;
    logic [7:0] rx_data_out;
    logic       rx_ready;
    logic       rx_error;

    int checks;
    int errors;

    uart_rx_core #(
        .WIDTH          (8),
        .SAMPLING_TICKS (16),
        .STOP_BITS      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baud_tick   (baud_tick),
        .rx_data_out (rx_data_out),
        .rx_ready    (rx_ready),
        .rx_error    (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running baud tick: one pulse every TICK_DIV clk.
    initial begin
        int cnt;
        cnt       = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = (cnt == TICK_DIV - 1);
            cnt       = (cnt + 1) % TICK_DIV;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    // Sends one full frame (start, 8 data bits LSB first, 1 stop bit).
    // With check_drop set, it also confirms that rx_ready falls shortly after the start edge.
    task automatic send_frame(input logic [7:0] data, input bit check_drop);
        rx = 1'b0;
        wait_clks(6);
        if (check_drop) check("ready_drop_at_start", rx_ready, 1'b0);
        wait_clks(BIT_CLKS - 6);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(1'b1);
    endtask

    task automatic check_good(input string tag, input logic [7:0] data);
        check({tag, "_data"},  rx_data_out, data);
        check({tag, "_ready"}, rx_ready, 1'b1);
        check({tag, "_error"}, rx_error, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx     = 1'b1;
        rst_n  = 1'b1;
        wait_clks(5);
        rst_n = 1'b0;
        wait_clks(2);
        check("reset_data",  rx_data_out, 8'h00);
        check("reset_ready", rx_ready, 1'b0);
        check("reset_error", rx_error, 1'b0);
        wait_clks(100);

        // Glitch: low for 4 ticks, so the start-bit centre sample is high.
        rx = 1'b0;
        wait_clks(4 * TICK_DIV);
        rx = 1'b1;
        wait_clks(10 * BIT_CLKS);
        check("glitch_data",  rx_data_out, 8'h00);
        check("glitch_ready", rx_ready, 1'b0);
        check("glitch_error", rx_error, 1'b0);

        // First valid frame. The flags must hold through the following idle time.
        send_frame(8'hA5, 1'b0);
        check_good("a5", 8'hA5);
        wait_clks(3 * BIT_CLKS);
        check("a5_hold_ready", rx_ready, 1'b1);
        check("a5_hold_data",  rx_data_out, 8'hA5);

        // Second frame. rx_ready must clear at the start edge.
        send_frame(8'h3C, 1'b1);
        check_good("3c", 8'h3C);
        wait_clks(2 * BIT_CLKS);

        // Line held low: all data bits read 0 and the stop bit reads low.
        rx = 1'b0;
        wait_clks(10 * BIT_CLKS);
        check("low_data",  rx_data_out, 8'h00);
        check("low_ready", rx_ready, 1'b0);
        check("low_error", rx_error, 1'b1);
        wait_clks(500);
        check("low_no_retrigger_error", rx_error, 1'b1);
        wait_clks(3 * BIT_CLKS);
        check("low_still_error", rx_error, 1'b1);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        send_frame(8'h5A, 1'b0);
        check_good("recover", 8'h5A);
        wait_clks(BIT_CLKS);

        // Reset in the middle of data bit 4 of a 0xFF frame.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b1;
        wait_clks(1);
        rst_n = 1'b0;
        wait_clks(1);
        check("midreset_data",  rx_data_out, 8'h00);
        check("midreset_ready", rx_ready, 1'b0);
        check("midreset_error", rx_error, 1'b0);
        wait_clks(6 * BIT_CLKS);
        check("midreset_no_flag", rx_ready, 1'b0);
        send_frame(8'h81, 1'b0);
        check_good("after_reset", 8'h81);

        // Back-to-back frames with no idle gap between them.
        send_frame(8'h55, 1'b0);
        check_good("b2b_55", 8'h55);
        send_frame(8'hAA, 1'b0);
        check_good("b2b_aa", 8'hAA);

        wait_clks(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
